commit_ctrl: RTL and testbench
==============================

Name: commit_ctrl

Overview:
- Consumer end of the write-back commit bundle; sits after the wb stage register.
- Per cycle it decides what retires from the two slots and gates the register-file and CSR writes of squashed instructions.
- Resolves exceptions, ertn and interrupts into a single-cycle pipeline flush with a redirect PC.
- Runs the idle wait state until an interrupt arrives.

Parameters:
- CAUSE_W, 7: width of each per-stage exception cause.
- NSTAGE, 6: number of per-stage exception flag bits (bit0 = pc stage ... bit5 = commit stage).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- commit_valid  in  2  per-slot valid; slot0 is older
- is_exception1 / is_exception2  in  NSTAGE  per-stage exception flags, slot0 / slot1
- cause_flat1 / cause_flat2  in  NSTAGE*CAUSE_W  per-stage causes, stage k at bits [k*CAUSE_W +: CAUSE_W]
- commit_pc1 / commit_pc2  in  32  slot PCs
- commit_addr1 / commit_addr2  in  32  memory addresses
- commit_idle, commit_ertn, commit_is_privilege  in  2  per-slot flags
- reg_we_i  in  2;  reg_waddr1_i / reg_waddr2_i  in  5;  reg_wdata1_i / reg_wdata2_i  in  32  incoming register writes
- csr_we_i  in  2;  csr_addr1_i / csr_addr2_i  in  14;  csr_wdata1_i / csr_wdata2_i  in  32  incoming CSR writes
- int_pending  in  1  unmasked interrupt pending, from CSR unit
- csr_eentry, csr_era  in  32  exception entry and return address
- rf_we  out  2;  rf_waddr1 / rf_waddr2  out  5;  rf_wdata1 / rf_wdata2  out  32  gated register writes
- csr_we  out  2;  csr_addr1 / csr_addr2  out  14;  csr_wdata1 / csr_wdata2  out  32  gated CSR writes
- flush  out  1  pipeline flush pulse
- flush_pc  out  32  redirect target
- exc_we  out  1  exception-entry CSR update strobe
- exc_cause  out  CAUSE_W  cause
- exc_era  out  32  return address
- exc_badv  out  32  bad virtual address
- exc_badv_we  out  1  badv write strobe
- ertn_o  out  1  restore PRMD strobe
- idle_stall  out  1  front end held

Behaviour:
- Write gating is combinational, zero latency:
  - kill0 = ~valid0 | exc0 | int_take.
  - kill1 = kill0 | ~valid1 | exc1 | ertn0 | idle0 | priv0.
  - rf_we[i] = reg_we_i[i] & ~kill_i. Same rule for csr_we.
  - Same-address writes in both slots are both forwarded; the register file gives slot1 priority.
- exc_s = |is_exception_s. Cause is taken from the lowest set stage index (earliest stage wins).
- Interrupt: int_take = int_pending & valid0 in RUN. It is taken before slot0: cause = INT, era = commit_pc1.
- Event priority: interrupt > slot0 exception > slot0 ertn > slot0 idle > slot0 privilege > slot1 exception > slot1 ertn/idle/privilege.
- Control outputs are registered, 1-cycle latency after the bundle.
- Exception event:
  - flush = 1, flush_pc = csr_eentry, exc_we = 1, exc_era = faulting pc.
  - exc_badv_we = 1 when the cause is in the fetch class (badv = pc) or the memory class (badv = commit_addr). Class is from the package.
- ertn: flush = 1, flush_pc = csr_era, ertn_o = 1.
- privilege (non-idle): flush = 1, flush_pc = pc + 4.
- idle: flush = 1, flush_pc = pc + 4; the idle PC + 4 is latched.
- FSM states:
  - RUN → FLUSH on any event. Exception while FLUSH is ignored.
  - FLUSH → RUN, or → IDLE when the event was idle. FLUSH lasts exactly 1 cycle, then all pulses drop.
  - IDLE: idle_stall = 1 and the bundle is ignored (all writes gated).
  - IDLE → FLUSH on int_pending, with INT exception: era = latched idle pc + 4, flush_pc = csr_eentry.
- Reset, asynchronous and mid-operation: state = RUN. All outputs 0, including flush_pc, exc_* and idle_stall. Gated write outputs are 0 while rst is low.
- pc + 4 wraps modulo 2^32.

Optional Feature:
- Macro COMMIT_TRACE_EN.
- Defined: adds outputs trace_valid[2], trace_pc1, trace_pc2 and a 32-bit trace_retired counter.
  - Registered, 1-cycle latency: valid = ~kill per slot.
  - Counter adds popcount(~kill) per cycle, wraps at 2^32, resets to 0.
- Undefined: ports and logic absent; no other behaviour change.

Decomposition:
- Package commit_pkg holds:
  - FSM state enum (RUN, FLUSH, IDLE).
  - CAUSE_INT constant.
  - Fetch-class and memory-class cause lists, with functions is_fetch_cause and is_mem_cause.
  - NSTAGE/CAUSE_W defaults.
- One sub-module, exc_prio_sel: priority-picks the cause from the flag vector plus the flat cause bus. Instanced once per slot.

Test Plan:
- Both valid, no exceptions, reg_we = 2'b11, waddr 3 and 4 → rf_we = 2'b11 same cycle; flush stays 0.
- Slot0 stage-2 flag, cause 0x0D, pc 0x1C000010 → rf_we = 0. Next cycle: flush = 1, flush_pc = csr_eentry 0x1C008000, exc_era = 0x1C000010, exc_cause = 0x0D. Flush for 1 cycle only.
- Slot0 flags stages 1 and 4 set, different causes → stage-1 cause selected. Memory-class cause with addr 0x00000003 → exc_badv = 3, exc_badv_we = 1.
- Slot0 ertn, slot1 valid write → rf_we[1] = 0. Next cycle: flush_pc = csr_era, ertn_o = 1.
- Slot0 idle at 0x1C000100 → flush_pc = 0x1C000104, then idle_stall held 10 cycles with bundle ignored. int_pending → flush_pc = eentry, exc_era = 0x1C000104, back to RUN.
- Assert rst low during FLUSH → flush = 0 immediately (asynchronous); after release state = RUN.

Source files
------------

// File: rtl/commit_pkg.sv
// Shared types, cause encodings and cause-class helpers for the commit controller.
package commit_pkg;

    localparam int CAUSE_W_DEF = 7;
    localparam int NSTAGE_DEF  = 6;

    typedef logic [CAUSE_W_DEF-1:0] cause_t;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_IDLE
    } state_e;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_EXC,
        EV_ERTN,
        EV_IDLE,
        EV_PRIV
    } event_e;

    localparam cause_t CAUSE_INT  = 7'h00;
    localparam cause_t CAUSE_PIL  = 7'h01;
    localparam cause_t CAUSE_PIS  = 7'h02;
    localparam cause_t CAUSE_PIF  = 7'h03;
    localparam cause_t CAUSE_PME  = 7'h04;
    localparam cause_t CAUSE_ADEF = 7'h08;
    localparam cause_t CAUSE_ALE  = 7'h09;
    localparam cause_t CAUSE_INE  = 7'h0D;
    // Address error on a data access: ADE code with the memory subcode in bit 6.
    localparam cause_t CAUSE_ADEM = 7'h48;

    localparam cause_t FETCH_CAUSES [2] = '{CAUSE_PIF, CAUSE_ADEF};
    localparam cause_t MEM_CAUSES   [5] = '{CAUSE_PIL, CAUSE_PIS, CAUSE_PME, CAUSE_ALE, CAUSE_ADEM};

    function automatic logic is_fetch_cause(input cause_t c);
        logic hit;
        hit = 1'b0;
        foreach (FETCH_CAUSES[i]) hit |= (c == FETCH_CAUSES[i]);
        return hit;
    endfunction

    function automatic logic is_mem_cause(input cause_t c);
        logic hit;
        hit = 1'b0;
        foreach (MEM_CAUSES[i]) hit |= (c == MEM_CAUSES[i]);
        return hit;
    endfunction

endpackage

// File: rtl/exc_prio_sel.sv
// Collapses per-stage exception flags of one slot into a flag and the cause of the earliest stage.
module exc_prio_sel
    import commit_pkg::*;
#(
    parameter int NSTAGE  = NSTAGE_DEF,
    parameter int CAUSE_W = CAUSE_W_DEF
) (
    input  logic [NSTAGE-1:0]         flags,
    input  logic [NSTAGE*CAUSE_W-1:0] cause_flat,
    output logic                      exc,
    output logic [CAUSE_W-1:0]        cause
);

    assign exc = |flags;

    // NOTE: every always_comb output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cause = '0;
        // Walk from the latest stage down so the earliest set stage is written last.
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (flags[k]) cause = cause_flat[k*CAUSE_W +: CAUSE_W];
        end
    end

endmodule

// File: rtl/commit_ctrl.sv
// Commit controller: gates write-back of squashed slots and turns exceptions, ertn, privilege
// and idle into a one-cycle flush. Optional trace outputs under `COMMIT_TRACE_EN.
module commit_ctrl
    import commit_pkg::*;
#(
    parameter int CAUSE_W = CAUSE_W_DEF,
    parameter int NSTAGE  = NSTAGE_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                commit_valid,
    input  logic [NSTAGE-1:0]         is_exception1,
    input  logic [NSTAGE-1:0]         is_exception2,
    input  logic [NSTAGE*CAUSE_W-1:0] cause_flat1,
    input  logic [NSTAGE*CAUSE_W-1:0] cause_flat2,
    input  logic [31:0]               commit_pc1,
    input  logic [31:0]               commit_pc2,
    input  logic [31:0]               commit_addr1,
    input  logic [31:0]               commit_addr2,
    input  logic [1:0]                commit_idle,
    input  logic [1:0]                commit_ertn,
    input  logic [1:0]                commit_is_privilege,
    input  logic [1:0]                reg_we_i,
    input  logic [4:0]                reg_waddr1_i,
    input  logic [4:0]                reg_waddr2_i,
    input  logic [31:0]               reg_wdata1_i,
    input  logic [31:0]               reg_wdata2_i,
    input  logic [1:0]                csr_we_i,
    input  logic [13:0]               csr_addr1_i,
    input  logic [13:0]               csr_addr2_i,
    input  logic [31:0]               csr_wdata1_i,
    input  logic [31:0]               csr_wdata2_i,
    input  logic                      int_pending,
    input  logic [31:0]               csr_eentry,
    input  logic [31:0]               csr_era,
    output logic [1:0]                rf_we,
    output logic [4:0]                rf_waddr1,
    output logic [4:0]                rf_waddr2,
    output logic [31:0]               rf_wdata1,
    output logic [31:0]               rf_wdata2,
    output logic [1:0]                csr_we,
    output logic [13:0]               csr_addr1,
    output logic [13:0]               csr_addr2,
    output logic [31:0]               csr_wdata1,
    output logic [31:0]               csr_wdata2,
    output logic                      flush,
    output logic [31:0]               flush_pc,
    output logic                      exc_we,
    output logic [CAUSE_W-1:0]        exc_cause,
    output logic [31:0]               exc_era,
    output logic [31:0]               exc_badv,
    output logic                      exc_badv_we,
    output logic                      ertn_o,
    output logic                      idle_stall
`ifdef COMMIT_TRACE_EN
    ,
    output logic [1:0]                trace_valid,
    output logic [31:0]               trace_pc1,
    output logic [31:0]               trace_pc2,
    output logic [31:0]               trace_retired
`endif
);

    state_e               state, state_nxt;
    event_e               ev;
    logic                 exc0, exc1, int_take, kill0, kill1;
    logic [CAUSE_W-1:0]   cause0, cause1, ev_cause;
    logic [31:0]          ev_pc, ev_addr;
    logic                 idle_pend, idle_pend_nxt;
    logic [31:0]          idle_ret, idle_ret_nxt;
    logic [1:0]           retire;

    logic                 flush_nxt, exc_we_nxt, exc_badv_we_nxt, ertn_nxt;
    logic [31:0]          flush_pc_nxt, exc_era_nxt, exc_badv_nxt;
    logic [CAUSE_W-1:0]   exc_cause_nxt;

    exc_prio_sel #(.NSTAGE(NSTAGE), .CAUSE_W(CAUSE_W)) u_sel0 (
        .flags      (is_exception1),
        .cause_flat (cause_flat1),
        .exc        (exc0),
        .cause      (cause0)
    );

    exc_prio_sel #(.NSTAGE(NSTAGE), .CAUSE_W(CAUSE_W)) u_sel1 (
        .flags      (is_exception2),
        .cause_flat (cause_flat2),
        .exc        (exc1),
        .cause      (cause1)
    );

    assign int_take = int_pending & commit_valid[0] & (state == ST_RUN);
    assign kill0    = ~commit_valid[0] | exc0 | int_take | (state == ST_IDLE);
    assign kill1    = kill0 | ~commit_valid[1] | exc1 | commit_ertn[0] | commit_idle[0]
                    | commit_is_privilege[0];
    assign retire   = {~kill1, ~kill0};

    // Write ports are combinational, so they are forced quiet while reset is held.
    assign rf_we      = reg_we_i & retire & {2{rst}};
    assign csr_we     = csr_we_i & retire & {2{rst}};
    assign rf_waddr1  = rst ? reg_waddr1_i : '0;
    assign rf_waddr2  = rst ? reg_waddr2_i : '0;
    assign rf_wdata1  = rst ? reg_wdata1_i : '0;
    assign rf_wdata2  = rst ? reg_wdata2_i : '0;
    assign csr_addr1  = rst ? csr_addr1_i  : '0;
    assign csr_addr2  = rst ? csr_addr2_i  : '0;
    assign csr_wdata1 = rst ? csr_wdata1_i : '0;
    assign csr_wdata2 = rst ? csr_wdata2_i : '0;

    assign idle_stall = (state == ST_IDLE);

    // Single highest-priority event of this cycle; slot1 only counts when slot0 retires cleanly.
    always_comb begin
        ev       = EV_NONE;
        ev_pc    = commit_pc1;
        ev_addr  = commit_addr1;
        ev_cause = CAUSE_INT;
        if (state == ST_IDLE) begin
            if (int_pending) begin
                ev    = EV_EXC;
                ev_pc = idle_ret;
            end
        end else if (state == ST_RUN) begin
            if (int_take) begin
                ev = EV_EXC;
            end else if (commit_valid[0] && exc0) begin
                ev       = EV_EXC;
                ev_cause = cause0;
            end else if (commit_valid[0] && commit_ertn[0]) begin
                ev = EV_ERTN;
            end else if (commit_valid[0] && commit_idle[0]) begin
                ev = EV_IDLE;
            end else if (commit_valid[0] && commit_is_privilege[0]) begin
                ev = EV_PRIV;
            end else if (commit_valid == 2'b11) begin
                ev_pc   = commit_pc2;
                ev_addr = commit_addr2;
                if (exc1) begin
                    ev       = EV_EXC;
                    ev_cause = cause1;
                end else if (commit_ertn[1]) begin
                    ev = EV_ERTN;
                end else if (commit_idle[1]) begin
                    ev = EV_IDLE;
                end else if (commit_is_privilege[1]) begin
                    ev = EV_PRIV;
                end
            end
        end
    end

    always_comb begin
        state_nxt       = state;
        idle_pend_nxt   = idle_pend;
        idle_ret_nxt    = idle_ret;
        flush_nxt       = 1'b0;
        flush_pc_nxt    = '0;
        exc_we_nxt      = 1'b0;
        exc_cause_nxt   = '0;
        exc_era_nxt     = '0;
        exc_badv_nxt    = '0;
        exc_badv_we_nxt = 1'b0;
        ertn_nxt        = 1'b0;

        unique case (state)
            ST_RUN, ST_IDLE: begin
                if (ev != EV_NONE) begin
                    state_nxt     = ST_FLUSH;
                    idle_pend_nxt = (ev == EV_IDLE);
                end
            end
            ST_FLUSH: begin
                state_nxt     = idle_pend ? ST_IDLE : ST_RUN;
                idle_pend_nxt = 1'b0;
            end
            default: state_nxt = ST_RUN;
        endcase

        if (ev == EV_IDLE) idle_ret_nxt = ev_pc + 32'd4;

        unique case (ev)
            EV_EXC: begin
                flush_nxt       = 1'b1;
                flush_pc_nxt    = csr_eentry;
                exc_we_nxt      = 1'b1;
                exc_cause_nxt   = ev_cause;
                exc_era_nxt     = ev_pc;
                exc_badv_we_nxt = is_fetch_cause(ev_cause) | is_mem_cause(ev_cause);
                exc_badv_nxt    = is_fetch_cause(ev_cause) ? ev_pc
                                : is_mem_cause(ev_cause)   ? ev_addr : 32'd0;
            end
            EV_ERTN: begin
                flush_nxt    = 1'b1;
                flush_pc_nxt = csr_era;
                ertn_nxt     = 1'b1;
            end
            EV_IDLE, EV_PRIV: begin
                flush_nxt    = 1'b1;
                flush_pc_nxt = ev_pc + 32'd4;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_RUN;
            idle_pend   <= 1'b0;
            idle_ret    <= '0;
            flush       <= 1'b0;
            flush_pc    <= '0;
            exc_we      <= 1'b0;
            exc_cause   <= '0;
            exc_era     <= '0;
            exc_badv    <= '0;
            exc_badv_we <= 1'b0;
            ertn_o      <= 1'b0;
        end else begin
            state       <= state_nxt;
            idle_pend   <= idle_pend_nxt;
            idle_ret    <= idle_ret_nxt;
            flush       <= flush_nxt;
            flush_pc    <= flush_pc_nxt;
            exc_we      <= exc_we_nxt;
            exc_cause   <= exc_cause_nxt;
            exc_era     <= exc_era_nxt;
            exc_badv    <= exc_badv_nxt;
            exc_badv_we <= exc_badv_we_nxt;
            ertn_o      <= ertn_nxt;
        end
    end

`ifdef COMMIT_TRACE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trace_valid   <= '0;
            trace_pc1     <= '0;
            trace_pc2     <= '0;
            trace_retired <= '0;
        end else begin
            trace_valid   <= retire;
            trace_pc1     <= commit_pc1;
            trace_pc2     <= commit_pc2;
            trace_retired <= trace_retired + {31'd0, retire[0]} + {31'd0, retire[1]};
        end
    end
`endif

endmodule

// File: tb/tb_commit_ctrl.sv
// Self-checking bench for commit_ctrl: inline checks on gated writes, scoreboard on registered control.
module tb_commit_ctrl;

    localparam int CAUSE_W = 7;
    localparam int NSTAGE  = 6;
    localparam logic [31:0] EENTRY = 32'h1C00_8000;
    localparam logic [31:0] ERA    = 32'h1C00_2000;
    localparam logic [6:0]  C_INT  = 7'h00;
    localparam logic [6:0]  C_ADEF = 7'h08;
    localparam logic [6:0]  C_ALE  = 7'h09;
    localparam logic [6:0]  C_INE  = 7'h0D;

    typedef struct packed {
        logic        flush;
        logic [31:0] flush_pc;
        logic        exc_we;
        logic [6:0]  cause;
        logic [31:0] era;
        logic [31:0] badv;
        logic        badv_we;
        logic        ertn;
        logic        idle_stall;
    } ctrl_t;

    logic clk, rst;
    logic [1:0] commit_valid, commit_idle, commit_ertn, commit_is_privilege;
    logic [NSTAGE-1:0] is_exception1, is_exception2;
    logic [NSTAGE*CAUSE_W-1:0] cause_flat1, cause_flat2;
    logic [31:0] commit_pc1, commit_pc2, commit_addr1, commit_addr2;
    logic [1:0] reg_we_i, csr_we_i;
    logic [4:0] reg_waddr1_i, reg_waddr2_i;
    logic [31:0] reg_wdata1_i, reg_wdata2_i, csr_wdata1_i, csr_wdata2_i;
    logic [13:0] csr_addr1_i, csr_addr2_i;
    logic int_pending;
    logic [31:0] csr_eentry, csr_era;
    logic [1:0] rf_we, csr_we;
    logic [4:0] rf_waddr1, rf_waddr2;
    logic [31:0] rf_wdata1, rf_wdata2, csr_wdata1, csr_wdata2;
    logic [13:0] csr_addr1, csr_addr2;
    logic flush, exc_we, exc_badv_we, ertn_o, idle_stall;
    logic [31:0] flush_pc, exc_era, exc_badv;
    logic [6:0] exc_cause;
`ifdef COMMIT_TRACE_EN
    logic [1:0]  trace_valid;
    logic [31:0] trace_pc1, trace_pc2, trace_retired;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    ctrl_t sb[$];

    commit_ctrl dut (
        .clk(clk), .rst(rst),
        .commit_valid(commit_valid),
        .is_exception1(is_exception1), .is_exception2(is_exception2),
        .cause_flat1(cause_flat1), .cause_flat2(cause_flat2),
        .commit_pc1(commit_pc1), .commit_pc2(commit_pc2),
        .commit_addr1(commit_addr1), .commit_addr2(commit_addr2),
        .commit_idle(commit_idle), .commit_ertn(commit_ertn),
        .commit_is_privilege(commit_is_privilege),
        .reg_we_i(reg_we_i), .reg_waddr1_i(reg_waddr1_i), .reg_waddr2_i(reg_waddr2_i),
        .reg_wdata1_i(reg_wdata1_i), .reg_wdata2_i(reg_wdata2_i),
        .csr_we_i(csr_we_i), .csr_addr1_i(csr_addr1_i), .csr_addr2_i(csr_addr2_i),
        .csr_wdata1_i(csr_wdata1_i), .csr_wdata2_i(csr_wdata2_i),
        .int_pending(int_pending), .csr_eentry(csr_eentry), .csr_era(csr_era),
        .rf_we(rf_we), .rf_waddr1(rf_waddr1), .rf_waddr2(rf_waddr2),
        .rf_wdata1(rf_wdata1), .rf_wdata2(rf_wdata2),
        .csr_we(csr_we), .csr_addr1(csr_addr1), .csr_addr2(csr_addr2),
        .csr_wdata1(csr_wdata1), .csr_wdata2(csr_wdata2),
        .flush(flush), .flush_pc(flush_pc), .exc_we(exc_we), .exc_cause(exc_cause),
        .exc_era(exc_era), .exc_badv(exc_badv), .exc_badv_we(exc_badv_we),
        .ertn_o(ertn_o), .idle_stall(idle_stall)
`ifdef COMMIT_TRACE_EN
        , .trace_valid(trace_valid), .trace_pc1(trace_pc1), .trace_pc2(trace_pc2),
        .trace_retired(trace_retired)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NSTAGE*CAUSE_W-1:0] flat(input int k, input logic [6:0] c);
        logic [NSTAGE*CAUSE_W-1:0] v;
        v = '0;
        v[k*CAUSE_W +: CAUSE_W] = c;
        return v;
    endfunction

    function automatic ctrl_t exp_exc(input logic [6:0] c, input logic [31:0] era,
                                      input logic [31:0] badv, input logic bwe);
        ctrl_t e;
        e = '0;
        e.flush = 1'b1; e.flush_pc = EENTRY; e.exc_we = 1'b1;
        e.cause = c; e.era = era; e.badv = badv; e.badv_we = bwe;
        return e;
    endfunction

    function automatic ctrl_t exp_redirect(input logic [31:0] pc);
        ctrl_t e;
        e = '0;
        e.flush = 1'b1; e.flush_pc = pc;
        return e;
    endfunction

    function automatic ctrl_t exp_idle();
        ctrl_t e;
        e = '0;
        e.idle_stall = 1'b1;
        return e;
    endfunction

    task automatic clear_bundle();
        commit_valid = '0; commit_idle = '0; commit_ertn = '0; commit_is_privilege = '0;
        is_exception1 = '0; is_exception2 = '0; cause_flat1 = '0; cause_flat2 = '0;
        commit_pc1 = '0; commit_pc2 = '0; commit_addr1 = '0; commit_addr2 = '0;
        reg_we_i = '0; reg_waddr1_i = '0; reg_waddr2_i = '0; reg_wdata1_i = '0; reg_wdata2_i = '0;
        csr_we_i = '0; csr_addr1_i = '0; csr_addr2_i = '0; csr_wdata1_i = '0; csr_wdata2_i = '0;
        int_pending = 1'b0;
    endtask

    // Push the expected registered response of the current bundle, clock it, then pop and compare.
    task automatic step(input string name, input ctrl_t e);
        ctrl_t got, want;
        sb.push_back(e);
        @(posedge clk);
        #1;
        want = sb.pop_front();
        got = {flush, flush_pc, exc_we, exc_cause, exc_era, exc_badv, exc_badv_we, ertn_o, idle_stall};
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got flush=%b pc=%h we=%b cause=%h era=%h badv=%h bwe=%b ertn=%b idle=%b, expected flush=%b pc=%h we=%b cause=%h era=%h badv=%h bwe=%b ertn=%b idle=%b",
                     name, got.flush, got.flush_pc, got.exc_we, got.cause, got.era, got.badv,
                     got.badv_we, got.ertn, got.idle_stall, want.flush, want.flush_pc, want.exc_we,
                     want.cause, want.era, want.badv, want.badv_we, want.ertn, want.idle_stall);
        end
    endtask

    task automatic test_reset();
        ctrl_t got;
        rst = 1'b1;
        clear_bundle();
        commit_valid = 2'b11; reg_we_i = 2'b11; csr_we_i = 2'b11; reg_waddr1_i = 5'd3;
        #2 rst = 1'b0;
        #1;
        got = {flush, flush_pc, exc_we, exc_cause, exc_era, exc_badv, exc_badv_we, ertn_o, idle_stall};
        tests_run++;
        if (got !== '0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %h expected 0", got);
        end
        tests_run++;
        if ({rf_we, csr_we, rf_waddr1} !== '0) begin
            tests_failed++;
            $display("FAIL reset_writes: got rf_we=%b csr_we=%b waddr1=%0d expected all 0",
                     rf_we, csr_we, rf_waddr1);
        end
        @(negedge clk) rst = 1'b1;
        clear_bundle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_normal_writes();
        clear_bundle();
        commit_valid = 2'b11; reg_we_i = 2'b11; csr_we_i = 2'b11;
        reg_waddr1_i = 5'd3; reg_waddr2_i = 5'd4;
        reg_wdata1_i = 32'hAAAA_0003; reg_wdata2_i = 32'hBBBB_0004;
        csr_addr1_i = 14'h005; csr_addr2_i = 14'h006;
        #1;
        tests_run++;
        if ({rf_we, csr_we, rf_waddr1, rf_waddr2, rf_wdata2} !== {2'b11, 2'b11, 5'd3, 5'd4, 32'hBBBB_0004}) begin
            tests_failed++;
            $display("FAIL both_retire: got rf_we=%b csr_we=%b wa=%0d/%0d wd2=%h expected 11 11 3/4 bbbb0004",
                     rf_we, csr_we, rf_waddr1, rf_waddr2, rf_wdata2);
        end
        step("both_retire_no_flush", '0);
        reg_waddr2_i = 5'd3;
        #1;
        tests_run++;
        if ({rf_we, rf_waddr2} !== {2'b11, 5'd3}) begin
            tests_failed++;
            $display("FAIL same_addr: got rf_we=%b waddr2=%0d expected 11 3", rf_we, rf_waddr2);
        end
        step("same_addr", '0);
        commit_valid = 2'b01;
        #1;
        tests_run++;
        if (rf_we !== 2'b01) begin
            tests_failed++;
            $display("FAIL slot1_invalid: got rf_we=%b expected 01", rf_we);
        end
        step("slot1_invalid", '0);
        commit_valid = 2'b10;
        #1;
        tests_run++;
        if ({rf_we, csr_we} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL slot0_invalid: got rf_we=%b csr_we=%b expected 00 00", rf_we, csr_we);
        end
        step("slot0_invalid", '0);
    endtask

    task automatic test_exception();
        clear_bundle();
        commit_valid = 2'b11; reg_we_i = 2'b11; csr_we_i = 2'b01;
        commit_pc1 = 32'h1C00_0010; is_exception1 = 6'b000100; cause_flat1 = flat(2, C_INE);
        #1;
        tests_run++;
        if ({rf_we, csr_we} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL exc_gate: got rf_we=%b csr_we=%b expected 00 00", rf_we, csr_we);
        end
        step("exc_flush", exp_exc(C_INE, 32'h1C00_0010, 32'd0, 1'b0));
        commit_pc1 = 32'h1C00_0020;
        step("exc_ignored_in_flush", '0);
        clear_bundle();
        step("exc_one_cycle", '0);
    endtask

    task automatic test_cause_priority();
        clear_bundle();
        commit_valid = 2'b01; commit_pc1 = 32'h1C00_0200; commit_addr1 = 32'h0000_0003;
        is_exception1 = 6'b010010; cause_flat1 = flat(1, C_ALE) | flat(4, C_INE);
        step("prio_stage1_mem", exp_exc(C_ALE, 32'h1C00_0200, 32'h0000_0003, 1'b1));
        clear_bundle();
        step("prio_drop", '0);
        commit_valid = 2'b01; commit_pc1 = 32'h1C00_0300; commit_addr1 = 32'h0000_DEAD;
        is_exception1 = 6'b100001; cause_flat1 = flat(0, C_ADEF) | flat(5, C_ALE);
        step("fetch_badv_pc", exp_exc(C_ADEF, 32'h1C00_0300, 32'h1C00_0300, 1'b1));
        clear_bundle();
        step("fetch_drop", '0);
        commit_valid = 2'b11; reg_we_i = 2'b11;
        commit_pc2 = 32'h1C00_0404; commit_addr2 = 32'h0000_0010;
        is_exception2 = 6'b001000; cause_flat2 = flat(3, C_ALE);
        #1;
        tests_run++;
        if (rf_we !== 2'b01) begin
            tests_failed++;
            $display("FAIL slot1_exc_gate: got rf_we=%b expected 01", rf_we);
        end
        step("slot1_exc", exp_exc(C_ALE, 32'h1C00_0404, 32'h0000_0010, 1'b1));
        clear_bundle();
        step("slot1_exc_drop", '0);
    endtask

    task automatic test_ertn_priv();
        ctrl_t e;
        clear_bundle();
        commit_valid = 2'b11; reg_we_i = 2'b11; commit_ertn = 2'b01;
        #1;
        tests_run++;
        if (rf_we !== 2'b01) begin
            tests_failed++;
            $display("FAIL ertn_gate: got rf_we=%b expected 01", rf_we);
        end
        e = exp_redirect(ERA);
        e.ertn = 1'b1;
        step("ertn", e);
        clear_bundle();
        step("ertn_drop", '0);
        commit_valid = 2'b11; reg_we_i = 2'b11; commit_is_privilege = 2'b01;
        commit_pc1 = 32'hFFFF_FFFC;
        #1;
        tests_run++;
        if (rf_we !== 2'b01) begin
            tests_failed++;
            $display("FAIL priv_gate: got rf_we=%b expected 01", rf_we);
        end
        step("priv_wrap", exp_redirect(32'h0000_0000));
        clear_bundle();
        step("priv_drop", '0);
        commit_valid = 2'b01; commit_ertn = 2'b01; commit_pc1 = 32'h1C00_0500;
        is_exception1 = 6'b100000; cause_flat1 = flat(5, C_INE);
        step("exc_beats_ertn", exp_exc(C_INE, 32'h1C00_0500, 32'd0, 1'b0));
        clear_bundle();
        step("exc_beats_ertn_drop", '0);
    endtask

    task automatic test_interrupt();
        clear_bundle();
        commit_valid = 2'b11; reg_we_i = 2'b11; commit_pc1 = 32'h1C00_0600;
        is_exception1 = 6'b000100; cause_flat1 = flat(2, C_INE); int_pending = 1'b1;
        #1;
        tests_run++;
        if (rf_we !== 2'b00) begin
            tests_failed++;
            $display("FAIL int_gate: got rf_we=%b expected 00", rf_we);
        end
        step("int_take", exp_exc(C_INT, 32'h1C00_0600, 32'd0, 1'b0));
        clear_bundle();
        step("int_drop", '0);
        int_pending = 1'b1;
        step("int_no_valid", '0);
        clear_bundle();
    endtask

    task automatic test_idle();
        ctrl_t e;
        clear_bundle();
        commit_valid = 2'b11; reg_we_i = 2'b11; commit_idle = 2'b01;
        commit_is_privilege = 2'b01; commit_pc1 = 32'h1C00_0100;
        #1;
        tests_run++;
        if (rf_we !== 2'b01) begin
            tests_failed++;
            $display("FAIL idle_gate: got rf_we=%b expected 01", rf_we);
        end
        step("idle_flush", exp_redirect(32'h1C00_0104));
        clear_bundle();
        step("idle_enter", exp_idle());
        for (int i = 0; i < 10; i++) begin
            commit_valid = 2'b11; reg_we_i = 2'b11; csr_we_i = 2'b11;
            commit_pc1 = 32'h1C00_0900 + 32'(i * 8);
            is_exception1 = 6'b000001; cause_flat1 = flat(0, C_INE); commit_idle = 2'b01;
            #1;
            tests_run++;
            if ({rf_we, csr_we} !== 4'b0000) begin
                tests_failed++;
                $display("FAIL idle_ignore[%0d]: got rf_we=%b csr_we=%b expected 00 00", i, rf_we, csr_we);
            end
            step("idle_hold", exp_idle());
        end
        clear_bundle();
        int_pending = 1'b1;
        e = exp_exc(C_INT, 32'h1C00_0104, 32'd0, 1'b0);
        step("idle_wake", e);
        clear_bundle();
        step("idle_back_run", '0);
        commit_valid = 2'b11; reg_we_i = 2'b11;
        #1;
        tests_run++;
        if (rf_we !== 2'b11) begin
            tests_failed++;
            $display("FAIL idle_resume_writes: got rf_we=%b expected 11", rf_we);
        end
        step("idle_resume", '0);
    endtask

    task automatic test_reset_mid();
        clear_bundle();
        commit_valid = 2'b01; commit_pc1 = 32'h1C00_0700;
        is_exception1 = 6'b000001; cause_flat1 = flat(0, C_INE);
        step("pre_reset_flush", exp_exc(C_INE, 32'h1C00_0700, 32'd0, 1'b0));
        clear_bundle();
        commit_valid = 2'b11; reg_we_i = 2'b11;
        #1 rst = 1'b0;
        #1;
        tests_run++;
        if ({flush, flush_pc, exc_we, exc_era} !== '0) begin
            tests_failed++;
            $display("FAIL async_reset: got flush=%b pc=%h we=%b era=%h expected 0",
                     flush, flush_pc, exc_we, exc_era);
        end
        tests_run++;
        if (rf_we !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_gate: got rf_we=%b expected 00", rf_we);
        end
        @(negedge clk) rst = 1'b1;
        clear_bundle();
        @(posedge clk);
        #1;
        commit_valid = 2'b11; reg_we_i = 2'b11; commit_is_privilege = 2'b01;
        commit_pc1 = 32'h1C00_0800;
        #1;
        tests_run++;
        if (rf_we !== 2'b01) begin
            tests_failed++;
            $display("FAIL post_reset_gate: got rf_we=%b expected 01", rf_we);
        end
        step("post_reset_run", exp_redirect(32'h1C00_0804));
        clear_bundle();
        step("post_reset_drop", '0);
    endtask

    initial begin
        csr_eentry = EENTRY;
        csr_era    = ERA;
        test_reset();
        test_normal_writes();
        test_exception();
        test_cause_priority();
        test_ertn_priv();
        test_interrupt();
        test_idle();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
